// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply/divide engine for the execute stage.
// Writes {hi,lo}; stalls the pipe while running and aborts on flush.
module muldiv_iter_unit #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dbz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 div_q;
    logic                 sa_q;
    logic                 sb_q;
    logic                 dz_q;
    logic [WIDTH-1:0]     opd_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     raw_a_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 done_q;
    logic                 dbz_q;

    logic                 sgn_a;
    logic                 sgn_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_sub;
    logic                 rem_ge;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   res_d;
    logic                 dbz_d;
    logic                 early_dz;

    // MIN negates to itself, which is exactly 2^(WIDTH-1) read unsigned
    assign sgn_a = op[0] & srca[WIDTH-1];
    assign sgn_b = op[0] & srcb[WIDTH-1];
    assign abs_a = sgn_a ? -srca : srca;
    assign abs_b = sgn_b ? -srcb : srcb;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, opd_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - opd_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            if (rem_ge) begin
                hi_d = rem_sub;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign prod = {hi_q, lo_q};

    always_comb begin
        res_d = '0;
        dbz_d = 1'b0;
        if (!div_q) begin
            res_d = (sa_q ^ sb_q) ? -prod : prod;
        end else if (dz_q) begin
            res_d = {raw_a_q, {WIDTH{1'b1}}};
            dbz_d = 1'b1;
        end else begin
            res_d[WIDTH-1:0]       = (sa_q ^ sb_q) ? -lo_q : lo_q;
            res_d[2*WIDTH-1:WIDTH] = sa_q ? -hi_q : hi_q;
        end
    end

    assign early_dz = EARLY_ZERO & div_q & dz_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            raw_a_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cancel) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            div_q   <= op[1];
                            sa_q    <= sgn_a;
                            sb_q    <= sgn_b;
                            dz_q    <= (srcb == '0);
                            raw_a_q <= srca;
                            hi_q    <= '0;
                            // divisor/multiplicand in opd, dividend/multiplier in lo
                            opd_q   <= op[1] ? abs_b : abs_a;
                            lo_q    <= op[1] ? abs_a : abs_b;
                        end
                    end
                    RUN: begin
                        if (cnt_q == LAST) begin
                            state_q  <= DONE;
                            result_q <= res_d;
                            dbz_q    <= dbz_d;
                            done_q   <= 1'b1;
                        end else begin
                            hi_q  <= hi_d;
                            lo_q  <= lo_d;
                            cnt_q <= early_dz ? LAST : cnt_q + 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy   = ((state_q == IDLE) & start & ~cancel) | (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit against an arithmetic model.
// Directed cases, cancel/reset aborts, then randomized operations.
module tb_muldiv_iter_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cancel = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  srca = '0;
    logic [W-1:0]  srcb = '0;
    logic          busy;
    logic          done;
    logic          dbz;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_res = '0;
    logic        exp_dbz = 1'b0;

    muldiv_iter_unit #(.WIDTH(W), .EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .cancel(cancel),
        .busy(busy), .done(done), .result(result), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {dbz, hi, lo} computed with plain 64-bit arithmetic
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o[1]) begin
            if (o[0]) p = 64'(sa * sb);
            else      p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o[0]) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [64:0] m;
        int n;
        int lat;
        bit busy_bad;
        m = model(o, a, b);
        lat = (o[1] && b == 32'd0) ? 2 : W + 1;
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        #1 chk({tag, ".busy_start"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        srca = $urandom; srcb = $urandom; op = 2'($urandom);
        n = 0;
        busy_bad = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".busy_run"}, 64'(busy_bad), 64'd0);
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        chk({tag, ".result"}, result, m[63:0]);
        chk({tag, ".dbz"}, 64'(dbz), 64'(m[64]));
        exp_res = m[63:0];
        exp_dbz = m[64];
        @(posedge clk);
        #1 chk({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    task automatic start_and_wait(input logic [1:0] o, input int k);
        @(negedge clk);
        op = o; srca = $urandom; srcb = $urandom | 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (k) @(posedge clk);
    endtask

    task automatic no_done(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done !== 1'b0) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int n;

        repeat (2) @(posedge clk);
        #1 chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.result", result, 64'd0);
        chk("rst.dbz", 64'(dbz), 64'd0);
        @(negedge clk) rst = 1'b1;

        run_op(2'b10, 32'd100, 32'd7, "udiv");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "sdiv_neg");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, "smul");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max");
        run_op(2'b10, 32'h0000_1234, 32'd0, "div_zero");

        // flush on RUN cycle 10 leaves the previous result intact
        start_and_wait(2'b11, 9);
        @(negedge clk) cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        chk("cancel.busy", 64'(busy), 64'd0);
        chk("cancel.done", 64'(done), 64'd0);
        chk("cancel.result", result, exp_res);
        chk("cancel.dbz", 64'(dbz), 64'(exp_dbz));
        run_op(2'b01, 32'h0000_0007, 32'hFFFF_FFFE, "after_cancel");

        start_and_wait(2'b10, 5);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.result", result, 64'd0);
        chk("midrst.dbz", 64'(dbz), 64'd0);
        no_done("midrst.no_done");
        run_op(2'b10, 32'd1000, 32'd33, "after_rst");

        @(negedge clk);
        op = 2'b10; srca = 32'd9; srcb = 32'd3; start = 1'b1; cancel = 1'b1;
        #1 chk("sc.busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        chk("sc.busy_after", 64'(busy), 64'd0);
        no_done("sc.no_done");

        // start held: second acceptance only from the following IDLE
        @(negedge clk);
        op = 2'b00; srca = 32'd12345; srcb = 32'd678; start = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (done === 1'b1) break;
        end
        chk("hold.lat1", 64'(n), 64'(W + 1));
        chk("hold.res1", result, 64'd12345 * 64'd678);
        @(posedge clk);
        #1 chk("hold.idle_done", 64'(done), 64'd0);
        chk("hold.idle_busy", 64'(busy), 64'd1);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        chk("hold.lat2", 64'(n), 64'(W + 2));
        @(posedge clk);
        #1 chk("hold.end_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(ro, ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised multi-cycle multiply/divide engine for the execute stage; writes the 2*WIDTH HI/LO pair.
- Drives the execute-stage stall while running, and a pipeline flush cancels it.
- Replaces a fixed 32-bit divide-only stall source with configurable width, signed/unsigned multiply and divide, a cancel input and early divide-by-zero termination.

Parameters:
- WIDTH, 32, operand width in bits. Must be a power of two, 8 or more.
- EARLY_ZERO, 1, when 1 a divide by zero completes in one RUN cycle instead of WIDTH cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  2  op[1]: 1=divide, 0=multiply; op[0]: 1=signed, 0=unsigned.
- srca  input  WIDTH  multiplicand or dividend.
- srcb  input  WIDTH  multiplier or divisor.
- cancel  input  1  abort (execute-stage flush).
- busy  output  1  stall request to hazard logic.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  2*WIDTH  multiply: {hi,lo} = product; divide: {hi=remainder, lo=quotient}.
- dbz  output  1  the last completed divide had srcb==0; held with result.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE; busy=0, done=0, result=0, dbz=0; iteration counter=0.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cancel=0 -> latch op, operand magnitudes and sign flags, then go to RUN with counter=0.
  - Signed operands use their absolute values. The absolute value of MIN is 2^(WIDTH-1) as unsigned.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. Counter increments.
  - After WIDTH steps, go to DONE.
  - Divide with srcb==0 and EARLY_ZERO=1: go to DONE after the first RUN cycle.
- DONE:
  - done=1 for exactly one cycle.
  - result and dbz are registered on entry to DONE and held until the next DONE or reset.
  - Next state is IDLE.
- Latency: start accepted at edge t -> done=1 in the cycle after edge t+WIDTH+1 (the DONE cycle). Zero divide with EARLY_ZERO=1: done after edge t+2.
- busy (combinational): (state==IDLE & start & ~cancel) | state==RUN.
  - busy is 0 in DONE, so the instruction leaves the execute stage on the same edge that result is consumed.
- Sign correction, applied when entering DONE:
  - Product: negated if sa^sb (2*WIDTH negate).
  - Quotient: negated if sa^sb.
  - Remainder: negated if sa, so the remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- Signed overflow: MIN / -1 gives quotient=MIN, remainder=0. No flag is raised.
- Divide by zero (either EARLY_ZERO setting):
  - result = {hi=srca as given, lo=all ones}; dbz=1.
  - A completed multiply clears dbz.
- cancel:
  - Any state with cancel=1 -> IDLE at the next edge.
  - done is suppressed; result and dbz are unchanged.
  - cancel and start in the same IDLE cycle: cancel wins, start is ignored, busy=0.
- start while in RUN or DONE is ignored. The pipeline holds start asserted while stalled; re-acceptance only happens from IDLE.
- Operands are read only at acceptance. Later changes to srca/srcb do not affect a running operation.
- Counter width: clog2(WIDTH)+1 bits; no wrap within one operation.

Test Plan:
- Unsigned divide, WIDTH=32, srca=100, srcb=7, op=2'b10:
  - busy=1 from the start cycle through the RUN cycles.
  - done is a single pulse 33 edges after acceptance; result hi=2, lo=14; dbz=0.
- Signed divide -7/2 (op=2'b11) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed divide 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Signed multiply -3*5 (op=2'b01) -> result=0xFFFFFFFF_FFFFFFF1.
- Unsigned multiply 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE_00000001.
- Divide 0x1234/0 with EARLY_ZERO=1 -> done 2 edges after acceptance; hi=0x1234, lo=0xFFFFFFFF; dbz=1. A following multiply clears dbz.
- cancel asserted on RUN cycle 10:
  - busy=0 the next cycle; no done pulse; result and dbz retain their previous values.
  - A start on the next cycle is accepted and completes correctly.
- Same for rst=0 mid-run, except all outputs are 0 afterwards.
- start and cancel asserted together in IDLE -> busy=0, state remains IDLE.
- start held high through DONE -> exactly one operation; the second acceptance happens only in the following IDLE cycle.
